// File: rtl/inst_fetch_unit_pkg.sv
// rtl/inst_fetch_unit_pkg.sv - shared fetch-stage types and constants
package inst_fetch_unit_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_FULL = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP              = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_skid_buf.sv
// rtl/fetch_skid_buf.sv - 1-entry {inst, pc} holding register with load/unload/flush
module fetch_skid_buf (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        unload,
  input  logic        flush,
  input  logic [31:0] load_inst,
  input  logic [31:0] load_pc,
  output logic        valid,
  output logic [31:0] inst,
  output logic [31:0] pc
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= 1'b0;
      inst  <= 32'd0;
      pc    <= 32'd0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      inst  <= load_inst;
      pc    <= load_pc;
    end else if (unload) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// rtl/inst_fetch_unit.sv - single-outstanding instruction fetch stage with output register and skid buffer
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        misalign_err
);

  fetch_state_e state, state_n;
  logic [31:0]  fetch_pc, req_pc;
  logic         drop, drop_n;
  logic         consume, req_fire;
  logic         resp_to_out, skid_load, skid_to_out;
  logic         skid_valid;
  logic [31:0]  skid_inst, skid_pc;

  assign consume        = inst_valid & ~stall;
  assign imem_req_valid = (state == S_REQ);
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid & imem_req_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_REQ;
    else      state <= state_n;
  end

  always_comb begin
    state_n     = state;
    drop_n      = drop;
    resp_to_out = 1'b0;
    skid_load   = 1'b0;
    skid_to_out = 1'b0;
    case (state)
      S_REQ: begin
        // A request accepted alongside a redirect belongs to the old path.
        if (req_fire) begin
          state_n = S_WAIT;
          drop_n  = redirect_valid;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          if (imem_resp_valid) begin
            state_n = S_REQ;
            drop_n  = 1'b0;
          end else begin
            drop_n  = 1'b1;
          end
        end else if (imem_resp_valid) begin
          state_n = S_REQ;
          if (drop) begin
            drop_n = 1'b0;
          end else if (!inst_valid || consume) begin
            resp_to_out = 1'b1;
          end else begin
            skid_load = 1'b1;
            state_n   = S_FULL;
          end
        end
      end
      S_FULL: begin
        if (redirect_valid) begin
          state_n = S_REQ;
        end else if (consume && skid_valid) begin
          skid_to_out = 1'b1;
          state_n     = S_REQ;
        end
      end
      default: state_n = S_REQ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop     <= 1'b0;
      fetch_pc <= RESET_PC;
      req_pc   <= 32'd0;
    end else begin
      drop <= drop_n;
      if (req_fire) req_pc <= fetch_pc;
      if (redirect_valid)  fetch_pc <= {redirect_target[31:2], 2'b00};
      else if (req_fire)   fetch_pc <= fetch_pc + 32'd4;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inst_valid   <= 1'b0;
      inst         <= 32'd0;
      pc           <= 32'd0;
      pc_plus4     <= 32'd4;
      misalign_err <= 1'b0;
    end else begin
      misalign_err <= redirect_valid & (|redirect_target[1:0]);
      if (redirect_valid) begin
        inst_valid <= 1'b0;
      end else if (resp_to_out) begin
        inst_valid <= 1'b1;
        inst       <= imem_resp_data;
        pc         <= req_pc;
        pc_plus4   <= req_pc + 32'd4;
      end else if (skid_to_out) begin
        inst_valid <= 1'b1;
        inst       <= skid_inst;
        pc         <= skid_pc;
        pc_plus4   <= skid_pc + 32'd4;
      end else if (consume) begin
        inst_valid <= 1'b0;
      end
    end
  end

  fetch_skid_buf u_skid (
    .clk       (clk),
    .rst       (rst),
    .load      (skid_load),
    .unload    (skid_to_out),
    .flush     (redirect_valid),
    .load_inst (imem_resp_data),
    .load_pc   (req_pc),
    .valid     (skid_valid),
    .inst      (skid_inst),
    .pc        (skid_pc)
  );

endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb/tb_inst_fetch_unit.sv - randomized bench for inst_fetch_unit against a program-order stream model
module tb_inst_fetch_unit;
  import inst_fetch_unit_pkg::*;

  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req_valid, imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data  = NOP;
  logic        stall = 1'b0, redirect_valid = 1'b0;
  logic [31:0] redirect_target = 32'd0;
  logic        inst_valid, misalign_err;
  logic [31:0] inst, pc, pc_plus4;

  int checks = 0, errors = 0;

  // Memory model: at most one pending response with a countdown.
  logic        pend = 1'b0;
  logic [31:0] pend_addr = 32'd0;
  int          pend_cnt = 0;
  int          resp_delay = 0;
  // Stream model: the next instruction decode should see, in program order.
  logic [31:0] exp_pc = 32'd0;
  logic        exp_mis = 1'b0;
  int          consumed = 0;
  logic        acc_seen = 1'b0;
  logic [31:0] acc_addr = 32'd0;

  always #5 clk = ~clk;

  inst_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .inst_valid      (inst_valid),
    .inst            (inst),
    .pc              (pc),
    .pc_plus4        (pc_plus4),
    .misalign_err    (misalign_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input logic st, input logic rd, input logic [31:0] tgt, input logic rdy);
    logic p_iv, p_acc;
    logic [31:0] p_addr;
    stall = st; redirect_valid = rd; redirect_target = tgt; imem_req_ready = rdy;
    imem_resp_valid = 1'b0;
    imem_resp_data  = NOP;
    if (pend && pend_cnt == 0) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = pend_addr ^ KEY;
      pend = 1'b0;
    end else if (pend) begin
      pend_cnt--;
    end
    p_iv   = inst_valid;
    p_acc  = imem_req_valid & rdy;
    p_addr = imem_req_addr;
    @(posedge clk); #1;
    if (rd) exp_pc = {tgt[31:2], 2'b00};
    else if (p_iv && !st) begin
      exp_pc = exp_pc + 32'd4;
      consumed++;
    end
    exp_mis = rd & (tgt[1:0] != 2'b00);
    if (p_acc) begin
      pend      = 1'b1;
      pend_addr = p_addr;
      pend_cnt  = (resp_delay < 0) ? int'($urandom_range(0, 3)) : resp_delay;
      acc_seen  = 1'b1;
      acc_addr  = p_addr;
    end
    check("misalign", {31'd0, misalign_err}, {31'd0, exp_mis});
    if (inst_valid) begin
      check("pc", pc, exp_pc);
      check("inst", inst, exp_pc ^ KEY);
      check("pc_plus4", pc_plus4, exp_pc + 32'd4);
    end
  endtask

  task automatic expect_next_acc(input string tag, input logic [31:0] addr);
    acc_seen = 1'b0;
    for (int i = 0; i < 40 && !acc_seen; i++) step(1'b0, 1'b0, 32'd0, 1'b1);
    check({tag, "_seen"}, {31'd0, acc_seen}, 32'd1);
    if (acc_seen) check(tag, acc_addr, addr);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_iv"}, {31'd0, inst_valid}, 32'd0);
    check({tag, "_inst"}, inst, 32'd0);
    check({tag, "_pc"}, pc, 32'd0);
    check({tag, "_pc4"}, pc_plus4, 32'd4);
    check({tag, "_mis"}, {31'd0, misalign_err}, 32'd0);
    check({tag, "_reqv"}, {31'd0, imem_req_valid}, 32'd1);
    check({tag, "_addr"}, imem_req_addr, 32'd0);
  endtask

  initial begin
    int start_cnt;
    int r;
    logic [31:0] t;

    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst = 1'b1;

    // Zero-wait startup
    resp_delay = 0;
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 32'd0, 1'b1);
    check("startup_progress", {31'd0, consumed >= 3}, 32'd1);

    // Restart from 0 stream-wise via redirect, then stall once output is valid
    step(1'b0, 1'b1, 32'd0, 1'b0);
    for (int i = 0; i < 20 && !inst_valid; i++) step(1'b0, 1'b0, 32'd0, 1'b1);
    step(1'b0, 1'b0, 32'd0, 1'b1);
    for (int i = 0; i < 20 && !inst_valid; i++) step(1'b0, 1'b0, 32'd0, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'd0, 1'b1);
    check("stall_hold_valid", {31'd0, inst_valid}, 32'd1);
    check("full_no_req", {31'd0, imem_req_valid}, 32'd0);
    start_cnt = consumed;
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 32'd0, 1'b1);
    check("stall_release_progress", {31'd0, consumed >= start_cnt + 2}, 32'd1);

    // Slow memory, redirect while waiting
    resp_delay = 3;
    for (int i = 0; i < 20 && !(pend && pend_cnt == 3); i++) step(1'b0, 1'b0, 32'd0, 1'b1);
    check("reached_wait", {31'd0, pend}, 32'd1);
    step(1'b0, 1'b1, 32'h0000_0100, 1'b0);
    expect_next_acc("redirect_wait_addr", 32'h0000_0100);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 32'd0, 1'b1);

    // Redirect on the same edge as the response
    resp_delay = 0;
    for (int i = 0; i < 20 && !(pend && pend_cnt == 0); i++) step(1'b0, 1'b0, 32'd0, 1'b1);
    step(1'b0, 1'b1, 32'h0000_0200, 1'b0);
    expect_next_acc("redirect_resp_addr", 32'h0000_0200);
    // Redirect on the same edge as request acceptance
    for (int i = 0; i < 20 && !imem_req_valid; i++) step(1'b0, 1'b0, 32'd0, 1'b1);
    step(1'b0, 1'b1, 32'h0000_0300, 1'b1);
    expect_next_acc("redirect_req_addr", 32'h0000_0300);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 32'd0, 1'b1);

    // Misaligned target
    step(1'b0, 1'b1, 32'h0000_0102, 1'b0);
    check("misalign_pulse", {31'd0, misalign_err}, 32'd1);
    expect_next_acc("misalign_addr", 32'h0000_0100);

    // Wrap-around
    step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
    expect_next_acc("wrap_first", 32'hFFFF_FFFC);
    expect_next_acc("wrap_second", 32'h0000_0000);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 32'd0, 1'b1);

    // Asynchronous reset while waiting on a response
    resp_delay = 3;
    for (int i = 0; i < 20 && !(pend && pend_cnt == 3); i++) step(1'b0, 1'b0, 32'd0, 1'b1);
    #2 rst = 1'b0;
    #1 check_reset_values("async_reset");
    rst = 1'b0;
    pend = 1'b0; exp_pc = 32'd0; exp_mis = 1'b0;
    #1 rst = 1'b1;
    expect_next_acc("post_reset_addr", 32'h0000_0000);

    // Randomized traffic
    resp_delay = -1;
    start_cnt = consumed;
    for (int i = 0; i < 1500; i++) begin
      r = int'($urandom_range(0, 3));
      case (r)
        0:       t = $urandom & 32'h0000_0FFC;
        1:       t = $urandom;
        2:       t = 32'hFFFF_FFF0 | ($urandom & 32'hF);
        default: t = ($urandom & 32'h0000_0FFC) | 32'd1;
      endcase
      step($urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0, t, $urandom_range(0, 9) < 7);
    end
    check("random_progress", {31'd0, consumed >= start_cnt + 100}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
Front-end fetch stage that produces the 32-bit instruction word and PC consumed by the decode/register-file stage. It holds the fetch PC, issues one request at a time to instruction memory, and buffers returned words in a 1-entry output register plus a 1-entry skid buffer. It accepts redirects (taken branch, jal, jalr) from downstream and discards any stale in-flight responses.

Parameters:
RESET_PC, 32'h0000_0000, fetch address loaded on reset.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-low reset.
imem_req_valid  out  1  fetch request valid.
imem_req_ready  in  1  memory accepts request this cycle.
imem_req_addr  out  32  word-aligned fetch address.
imem_resp_valid  in  1  response word valid; at most one per accepted request, arriving no earlier than the cycle after acceptance.
imem_resp_data  in  32  instruction word.
stall  in  1  decode cannot consume the instruction this cycle.
redirect_valid  in  1  replace the fetch PC with redirect_target.
redirect_target  in  32  new PC.
inst_valid  out  1  inst/pc hold a valid instruction.
inst  out  32  instruction word to decode.
pc  out  32  address of inst.
pc_plus4  out  32  pc + 4, mod 2^32.
misalign_err  out  1  one-cycle pulse when redirect_target[1:0] != 0.

Behaviour:
- Reset (rst=0, asynchronous):
  - fetch_pc = RESET_PC; state = REQ.
  - inst_valid = 0; inst = 0; pc = 0; pc_plus4 = 4; misalign_err = 0.
  - Skid buffer empty; drop flag = 0.
- A reset asserted mid-request abandons the request. The memory side must tolerate this.
- States:
  - REQ: imem_req_valid = 1; imem_req_addr = fetch_pc. On imem_req_ready, go to WAIT, set req_pc = fetch_pc, and advance fetch_pc += 4.
  - WAIT: waiting for the response.
    - On imem_resp_valid with drop = 1: discard the word, clear drop, go to REQ.
    - Otherwise, if the output register is empty or is being consumed this cycle (inst_valid & ~stall): load inst/pc from the response/req_pc and go to REQ.
    - Otherwise: write the word and req_pc to the skid buffer and go to FULL.
  - FULL: output register and skid buffer are both occupied; no requests issued. When the output is consumed, the skid contents move into the output register (same-edge transfer) and the state goes to REQ.
- imem_req_valid depends only on state; it is never combinationally gated by redirect or stall.
- Consumption: the output is consumed on any edge where inst_valid = 1 and stall = 0. If nothing refills it, inst_valid drops to 0 on that edge.
- pc_plus4 is registered alongside pc.
- Redirect (highest priority, takes effect on the edge it is sampled):
  - Clear inst_valid and the skid buffer.
  - fetch_pc = {redirect_target[31:2], 2'b00}; misalign_err pulses for 1 cycle if redirect_target[1:0] != 0.
  - In REQ with imem_req_ready the same cycle: the request is accepted, go to WAIT with drop = 1.
  - In REQ without ready: stay in REQ; the next request uses the new PC.
  - In WAIT without imem_resp_valid: stay in WAIT, set drop = 1.
  - In WAIT with imem_resp_valid the same cycle: discard the response, go to REQ, drop = 0.
  - In FULL: go to REQ.
- Redirect plus stall in the same cycle: the redirect wins; the output is flushed regardless of stall.
- Wrap-around: fetch_pc 32'hFFFF_FFFC advances to 32'h0000_0000 with no error.
- Throughput: one instruction per 2 cycles with zero-wait memory; no throughput requirement beyond that. Latency from response to inst_valid is 1 edge.

Decomposition:
- Shared cpu package holds:
  - the fetch state encoding (REQ, WAIT, FULL);
  - the NOP constant 32'h0000_0013, used by the bench as filler;
  - the RESET_PC default.
- One sub-module is natural: fetch_skid_buf, a 1-entry {inst, pc} holding register with load/unload/flush.

Test Plan:
- Reset release, zero-wait memory returning addr^32'hA5A5_0000, stall=0 -> first request addr 0x0. inst_valid sequence shows pc 0x0, 0x4, 0x8 with matching data. No misalign_err.
- stall held 5 cycles after the first valid instruction -> inst/pc stay at 0x4. State reaches FULL with the word for 0x8 in skid. imem_req_valid=0 until stall releases. Next outputs are 0x8 then 0xC, nothing lost or duplicated.
- Memory response delayed 3 cycles and redirect to 0x100 asserted in WAIT -> the late response for the old address is discarded. Next request addr is 0x100, and the first inst_valid shows pc=0x100.
- Redirect and imem_resp_valid in the same cycle, and separately redirect and imem_req_ready in the same cycle -> in both cases no instruction from the old path ever appears with inst_valid=1.
- redirect_target=0x0000_0102 -> misalign_err high for exactly 1 cycle. Next fetch addr is 0x100.
- RESET_PC=32'hFFFF_FFFC -> pcs seen are 0xFFFF_FFFC then 0x0. rst asserted while in WAIT -> all outputs return to their reset values immediately, without waiting for a clock edge.
